// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES key scheduler, one 48-bit subkey per valid/ready handshake
// Ports:
//   CLK, RST_N           rising-edge clock, asynchronous active-low reset
//   START, DECRYPT, KEY  request, order select and 64-bit key, sampled together in IDLE
//   SK_VALID, SK_READY   subkey handshake
//   SUBKEY, SK_IDX       PC-2 of the current C/D state and its subkey number 1..16
//   BUSY, DONE           not idle; one-cycle pulse after the last subkey is accepted
module des_key_schedule #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        DECRYPT,
    input  logic [64:1] KEY,
    output logic        SK_VALID,
    input  logic        SK_READY,
    output logic [48:1] SUBKEY,
    output logic [4:0]  SK_IDX,
    output logic        BUSY,
    output logic        DONE
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    localparam logic [4:0] LAST = 5'(NUM_ROUNDS);
    // Tables hold FIPS bit numbers where bit 1 is the MSB.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    function automatic logic [55:0] pc1(input logic [64:1] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[65-PC1[i]];
        return r;
    endfunction
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction
    // Shift schedule: single shift for rounds 1, 2, 9 and 16, double otherwise.
    function automatic logic dbl(input logic [4:0] n);
        return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
    endfunction
    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction
    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction
    logic [0:0]  state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [4:0]  idx_q, idx_d;
    logic        dec_q, dec_d, done_q, done_d;
    logic [55:0] cd0;
    logic        last;
    assign cd0  = pc1(KEY);
    assign last = dec_q ? (idx_q == 5'd1) : (idx_q == LAST);
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (START) begin
                // PC-1 output already equals C16/D16, so decryption starts unrotated.
                c_d     = DECRYPT ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
                d_d     = DECRYPT ? cd0[27:0]  : rotl(cd0[27:0], 1'b0);
                idx_d   = DECRYPT ? LAST : 5'd1;
                dec_d   = DECRYPT;
                state_d = EMIT;
            end
        end else if (SK_READY) begin
            if (last) begin
                state_d = IDLE;
                idx_d   = 5'd0;
                done_d  = 1'b1;
            end else if (dec_q) begin
                c_d   = rotr(c_q, dbl(idx_q));
                d_d   = rotr(d_q, dbl(idx_q));
                idx_d = idx_q - 5'd1;
            end else begin
                c_d   = rotl(c_q, dbl(idx_q + 5'd1));
                d_d   = rotl(d_q, dbl(idx_q + 5'd1));
                idx_d = idx_q + 5'd1;
            end
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end
    assign SUBKEY   = pc2({c_q, d_q});
    assign SK_VALID = (state_q == EMIT);
    assign BUSY     = (state_q == EMIT);
    assign SK_IDX   = idx_q;
    assign DONE     = done_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: scoreboard bench for des_key_schedule with directed FIPS key vectors
module tb_des_key_schedule;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        DECRYPT = 1'b0;
    logic [64:1] KEY = '0;
    logic        SK_VALID;
    logic        SK_READY = 1'b1;
    logic [48:1] SUBKEY;
    logic [4:0]  SK_IDX;
    logic        BUSY;
    logic        DONE;

    des_key_schedule dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .DECRYPT(DECRYPT), .KEY(KEY),
        .SK_VALID(SK_VALID), .SK_READY(SK_READY), .SUBKEY(SUBKEY), .SK_IDX(SK_IDX),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    localparam logic [63:0] K_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] K_PAR = 64'h123556789ABDDEF0;
    localparam logic [47:0] ENC [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

    typedef struct {
        logic [4:0]  idx;
        logic [47:0] sk;
    } exp_t;
    exp_t q[$];
    int   vec = 0;
    int   err = 0;
    logic done_exp = 1'b0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vec++;
        if (a !== e) begin
            err++;
            $display("FAIL %s: got %h, expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic popped;
        popped = 1'b0;
        if (RST_N) begin
            chk("sk_valid", 64'(SK_VALID), 64'(q.size() != 0));
            chk("busy", 64'(BUSY), 64'(q.size() != 0));
            chk("done", 64'(DONE), 64'(done_exp));
            if (SK_VALID && q.size() != 0) begin
                chk("sk_idx", 64'(SK_IDX), 64'(q[0].idx));
                chk("subkey", 64'(SUBKEY), 64'(q[0].sk));
                if (SK_READY) begin
                    void'(q.pop_front());
                    popped = 1'b1;
                end
            end
        end
        done_exp = popped && q.size() == 0;
    end

    // mode 0: ready held high, 1: random ready, 2: ready high plus ignored START pulses
    task automatic run(input logic [63:0] k, input logic dec, input int mode, input int stop_at);
        bit ok;
        ok = 1'b0;
        @(posedge CLK); #1;
        START = 1'b1; KEY = k; DECRYPT = dec; SK_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; KEY = ~k; DECRYPT = ~dec;
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.idx = dec ? 5'(16 - i) : 5'(i + 1);
            e.sk  = dec ? ENC[15-i] : ENC[i];
            q.push_back(e);
        end
        for (int n = 0; n < 300; n++) begin
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            if (stop_at >= 0 && q.size() == stop_at) begin
                chk("idx_before_reset", 64'(SK_IDX), 64'd7);
                #2 RST_N = 1'b0;
                q.delete();
                #1;
                chk("rst_sk_valid", 64'(SK_VALID), 64'd0);
                chk("rst_busy", 64'(BUSY), 64'd0);
                chk("rst_sk_idx", 64'(SK_IDX), 64'd0);
                chk("rst_subkey", 64'(SUBKEY), 64'd0);
                repeat (2) @(posedge CLK);
                #3 RST_N = 1'b1;
                return;
            end
            START = (mode == 2) && (q.size() == 12 || q.size() == 1);
            if (START) begin
                KEY = 64'h0F1E2D3C4B5A6978;
                DECRYPT = ~dec;
            end
            SK_READY = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge CLK); #1;
        end
        START = 1'b0;
        SK_READY = 1'b1;
        chk("sequence_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_sk_valid", 64'(SK_VALID), 64'd0);
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_done", 64'(DONE), 64'd0);
        chk("reset_sk_idx", 64'(SK_IDX), 64'd0);
        chk("reset_subkey", 64'(SUBKEY), 64'd0);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        run(K_STD, 1'b0, 0, -1);
        run(K_STD, 1'b1, 0, -1);
        run(K_STD, 1'b0, 1, -1);
        run(K_STD, 1'b1, 1, -1);
        run(K_STD, 1'b0, 2, -1);
        run(K_STD, 1'b0, 0, 10);
        repeat (3) @(posedge CLK);
        run(K_STD, 1'b0, 0, -1);
        run(K_PAR, 1'b0, 0, -1);
        run(K_PAR, 1'b1, 1, -1);
        repeat (4) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
